inta_seq: RTL and testbench



---
 rtl/inta_seq_if.sv | 23 ++
 rtl/inta_seq.sv | 118 +++++++++++
 tb/tb_inta_seq.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/inta_seq_if.sv
// Handshake/bus bundle between the 8259A pins, the INTA# sequencer and the
// CPU core's interrupt entry port. master = sequencer side, slave = environment.
interface inta_seq_if;
  logic       intr;
  logic       if_en;
  logic [7:0] data_in;
  logic       inta_n;
  logic       lock_n;
  logic       busy;
  logic       vec_valid;
  logic       vec_ready;
  logic [7:0] vector;

  modport master (
    input  intr, if_en, data_in, vec_ready,
    output inta_n, lock_n, busy, vec_valid, vector
  );

  modport slave (
    output intr, if_en, data_in, vec_ready,
    input  inta_n, lock_n, busy, vec_valid, vector
  );
endinterface

// File: rtl/inta_seq.sv
// inta_seq: 8086-style two-pulse INTA# sequencer with LOCK#.
// On an enabled request it runs P1 (INTA# low, LOCK# low), G1 (INTA# high,
// LOCK# low), P2 (INTA# low, LOCK# high), captures the vector on the edge
// that ends P2 and offers it to the core over vec_valid/vec_ready.
// Optional feature: define INTA_SYNC_EN to pass intr through a two-flop
// synchronizer (adds two cycles of request latency).
module inta_seq #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  inta_seq_if.master bus
);
  localparam int MAXW = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CW   = $clog2(MAXW) + 1;
  localparam logic [CW-1:0] PLAST = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] GLAST = CW'(GAP_W - 1);

  typedef enum logic [2:0] {IDLE, P1, G1, P2, VEC} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          intr_q;
  logic          inta_r, lock_r, busy_r, vld_r;
  logic [7:0]    vec_r;

`ifdef INTA_SYNC_EN
  logic [1:0] sync;
  // two-flop synchronizer for an intr that is asynchronous to clk
  always_ff @(posedge clk) begin
    if (!reset_n) sync <= 2'b00;
    else          sync <= {sync[0], bus.intr};
  end
  assign intr_q = sync[1];
`else
  assign intr_q = bus.intr;
`endif

  // sequencer FSM; every output is registered and changes with the state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      inta_r <= 1'b1;
      lock_r <= 1'b1;
      busy_r <= 1'b0;
      vld_r  <= 1'b0;
      vec_r  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (intr_q && bus.if_en) begin
            state  <= P1;
            cnt    <= '0;
            inta_r <= 1'b0;
            lock_r <= 1'b0;
            busy_r <= 1'b1;
          end
        end
        P1: begin
          if (cnt == PLAST) begin
            state  <= G1;
            cnt    <= '0;
            inta_r <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        G1: begin
          if (cnt == GLAST) begin
            state  <= P2;
            cnt    <= '0;
            inta_r <= 1'b0;
            lock_r <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        P2: begin
          // the 8259A drives the vector during the second pulse; take it on
          // the edge that closes the pulse
          if (cnt == PLAST) begin
            state  <= VEC;
            cnt    <= '0;
            inta_r <= 1'b1;
            vld_r  <= 1'b1;
            vec_r  <= bus.data_in;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        VEC: begin
          // IDLE after this edge guarantees one cycle before intr is re-sampled
          if (bus.vec_ready) begin
            state  <= IDLE;
            vld_r  <= 1'b0;
            busy_r <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          inta_r <= 1'b1;
          lock_r <= 1'b1;
          busy_r <= 1'b0;
          vld_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.inta_n    = inta_r;
  assign bus.lock_n    = lock_r;
  assign bus.busy      = busy_r;
  assign bus.vec_valid = vld_r;
  assign bus.vector    = vec_r;
endmodule

// File: tb/tb_inta_seq.sv
// Bench for inta_seq: dut_a uses the default timing, dut_b uses PULSE_W=1,
// GAP_W=3 (request latency depends on whether INTA_SYNC_EN is defined).
// Stimulus pushes expected vectors into per-DUT queues; a negedge monitor
// pops and compares on every vec_valid && vec_ready transfer.
module tb_inta_seq;
  localparam int PA = 2, GA = 2;
  localparam int PB = 1, GB = 3;
`ifdef INTA_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  inta_seq_if a_if ();
  inta_seq_if b_if ();

  inta_seq #(.PULSE_W(PA), .GAP_W(GA)) dut_a (.clk(clk), .reset_n(reset_n), .bus(a_if.master));
  inta_seq #(.PULSE_W(PB), .GAP_W(GB)) dut_b (.clk(clk), .reset_n(reset_n), .bus(b_if.master));

  int errs = 0;
  int checks = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] exp_a, exp_b;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitors: a transfer happens at the coming edge
  always @(negedge clk) begin
    if (reset_n && a_if.vec_valid && a_if.vec_ready) begin
      if (qa.size() == 0) begin
        checks++; errs++;
        $display("FAIL sb_a: unexpected vector %0h", a_if.vector);
      end else begin
        exp_a = qa.pop_front();
        chk("sb_a vector", {24'h0, a_if.vector}, {24'h0, exp_a});
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && b_if.vec_valid && b_if.vec_ready) begin
      if (qb.size() == 0) begin
        checks++; errs++;
        $display("FAIL sb_b: unexpected vector %0h", b_if.vector);
      end else begin
        exp_b = qb.pop_front();
        chk("sb_b vector", {24'h0, b_if.vector}, {24'h0, exp_b});
      end
    end
  end

  // One full sequence on dut_a, checked cycle by cycle from E0.
  // drop: release intr/if_en in G1; nwait: VEC cycles with vec_ready low;
  // early: vec_ready held high from the start.
  task automatic run_a(input logic [7:0] v, input bit drop, input int nwait, input bit early);
    a_if.intr = 1'b1; a_if.if_en = 1'b1; a_if.data_in = 8'h00;
    a_if.vec_ready = early;
    for (int k = 0; k < 2*PA+GA; k++) begin
      step();
      chk($sformatf("a inta_n k=%0d", k), a_if.inta_n, (k < PA || k >= PA+GA) ? 0 : 1);
      chk($sformatf("a lock_n k=%0d", k), a_if.lock_n, (k < PA+GA) ? 0 : 1);
      chk($sformatf("a busy k=%0d", k), a_if.busy, 1);
      chk($sformatf("a vec_valid k=%0d", k), a_if.vec_valid, 0);
      if (drop && k == PA) begin a_if.intr = 1'b0; a_if.if_en = 1'b0; end
      if (k == PA+GA) a_if.data_in = v;
    end
    step();
    chk("a vec_valid at E0+2P+G", a_if.vec_valid, 1);
    chk("a vector at capture", a_if.vector, v);
    chk("a inta_n in VEC", a_if.inta_n, 1);
    chk("a lock_n in VEC", a_if.lock_n, 1);
    qa.push_back(v);
    if (!early) begin
      for (int w = 0; w < nwait; w++) begin
        a_if.data_in = ~a_if.data_in;
        step();
        chk($sformatf("a hold valid w=%0d", w), a_if.vec_valid, 1);
        chk($sformatf("a hold vector w=%0d", w), a_if.vector, v);
        chk($sformatf("a hold busy w=%0d", w), a_if.busy, 1);
      end
      a_if.vec_ready = 1'b1;
    end
    a_if.intr = 1'b0;
    step();
    chk("a vec_valid after handshake", a_if.vec_valid, 0);
    chk("a busy after handshake", a_if.busy, 0);
    a_if.vec_ready = 1'b0; a_if.if_en = 1'b0;
    step();
    chk("a idle inta_n", a_if.inta_n, 1);
  endtask

  initial begin
    a_if.intr = 0; a_if.if_en = 0; a_if.data_in = 0; a_if.vec_ready = 0;
    b_if.intr = 0; b_if.if_en = 0; b_if.data_in = 0; b_if.vec_ready = 0;
    reset_n = 1'b0;
    step(); step();
    chk("rst a inta_n", a_if.inta_n, 1);
    chk("rst a lock_n", a_if.lock_n, 1);
    chk("rst a busy", a_if.busy, 0);
    chk("rst a vec_valid", a_if.vec_valid, 0);
    chk("rst a vector", a_if.vector, 8'h00);
    chk("rst b inta_n", b_if.inta_n, 1);
    chk("rst b busy", b_if.busy, 0);
    reset_n = 1'b1;
    step();

    // basic sequence
    run_a(8'h4B, 1'b0, 0, 1'b0);
    // backpressure for 5 cycles while data_in toggles
    run_a(8'h5C, 1'b0, 5, 1'b0);

    // mask: intr high, if_en low for 20 cycles
    a_if.intr = 1'b1; a_if.if_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("mask inta_n i=%0d", i), a_if.inta_n, 1);
      chk($sformatf("mask busy i=%0d", i), a_if.busy, 0);
    end
    run_a(8'h61, 1'b0, 0, 1'b0);

    // intr/if_en dropped in G1: sequence still completes
    run_a(8'h27, 1'b1, 0, 1'b0);
    // vec_ready held high before the vector appears
    run_a(8'h3E, 1'b0, 0, 1'b1);

    // reset in the second cycle of P2
    a_if.intr = 1'b1; a_if.if_en = 1'b1; a_if.data_in = 8'h00;
    for (int k = 0; k < 2*PA+GA; k++) begin
      step();
      if (k == PA+GA) a_if.data_in = 8'h99;
    end
    chk("pre-reset inta_n in P2", a_if.inta_n, 0);
    reset_n = 1'b0;
    step();
    chk("midrst inta_n", a_if.inta_n, 1);
    chk("midrst lock_n", a_if.lock_n, 1);
    chk("midrst vec_valid", a_if.vec_valid, 0);
    chk("midrst vector", a_if.vector, 8'h00);
    chk("midrst busy", a_if.busy, 0);
    a_if.intr = 1'b0; a_if.if_en = 1'b0; a_if.data_in = 8'h00;
    reset_n = 1'b1;
    step();
    chk("post-rst busy", a_if.busy, 0);
    chk("post-rst vec_valid", a_if.vec_valid, 0);

    // dut_b: PULSE_W=1, GAP_W=3, latency per synchronizer option
    b_if.intr = 1'b1; b_if.if_en = 1'b1; b_if.data_in = 8'h00;
    for (int i = 0; i < LAT-1; i++) begin
      step();
      chk($sformatf("b latency inta_n i=%0d", i), b_if.inta_n, 1);
      chk($sformatf("b latency busy i=%0d", i), b_if.busy, 0);
    end
    for (int k = 0; k < 2*PB+GB; k++) begin
      step();
      chk($sformatf("b inta_n k=%0d", k), b_if.inta_n, (k < PB || k >= PB+GB) ? 0 : 1);
      chk($sformatf("b lock_n k=%0d", k), b_if.lock_n, (k < PB+GB) ? 0 : 1);
      chk($sformatf("b vec_valid k=%0d", k), b_if.vec_valid, 0);
      if (k == 0) b_if.intr = 1'b0;
      if (k == PB+GB-1) b_if.data_in = 8'hA5;
    end
    step();
    chk("b vec_valid at E0+5", b_if.vec_valid, 1);
    chk("b vector", b_if.vector, 8'hA5);
    qb.push_back(8'hA5);
    b_if.vec_ready = 1'b1;
    step();
    chk("b vec_valid after handshake", b_if.vec_valid, 0);
    chk("b busy after handshake", b_if.busy, 0);
    b_if.vec_ready = 1'b0; b_if.if_en = 1'b0;
    step(); step();
    chk("b stays idle", b_if.busy, 0);

    chk("sb_a drained", qa.size(), 0);
    chk("sb_b drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
